// File: rtl/sha3_scan_job_sequencer_if.sv
// Job / scanner / result channels between the host-side requester, the job
// sequencer and the shared sha3 scanner.
interface sha3_scan_job_sequencer_if #(
  parameter int INPUT_ELEMENTS = 20,
  parameter int ID_W           = 8
);
  logic                           job_valid;
  logic                           job_ready;
  logic [63:0]                    job_threshold;
  logic [INPUT_ELEMENTS-1:0][31:0] job_blobby;
  logic [31:0]                    job_budget;

  logic                           scan_start;
  logic [63:0]                    scan_threshold;
  logic [INPUT_ELEMENTS-1:0][31:0] scan_blobby;
  logic                           scan_busy;
  logic                           scan_capture;
  logic [31:0]                    scan_nonce;
  logic [31:0]                    scan_count;

  logic                           res_valid;
  logic                           res_ready;
  logic [ID_W-1:0]                res_id;
  logic                           res_found;
  logic [31:0]                    res_nonce;
  logic [31:0]                    res_scanned;
  logic [15:0]                    stale_drops;
  logic [1:0]                     seq_state;

  modport slave (
    input  job_valid, job_threshold, job_blobby, job_budget,
    output job_ready,
    output scan_start, scan_threshold, scan_blobby,
    input  scan_busy, scan_capture, scan_nonce, scan_count,
    output res_valid, res_id, res_found, res_nonce, res_scanned,
    input  res_ready,
    output stale_drops, seq_state
  );

  modport master (
    output job_valid, job_threshold, job_blobby, job_budget,
    input  job_ready,
    input  scan_start, scan_threshold, scan_blobby,
    output scan_busy, scan_capture, scan_nonce, scan_count,
    input  res_valid, res_id, res_found, res_nonce, res_scanned,
    output res_ready,
    input  stale_drops, seq_state
  );
endinterface

// File: rtl/sha3_scan_job_sequencer.sv
// Queues scan jobs and runs them one at a time on a shared scanner, closing each
// job on first capture or budget exhaustion and returning one result record.
module sha3_scan_job_sequencer #(
  parameter int INPUT_ELEMENTS = 20,
  parameter int QUEUE_DEPTH    = 2,
  parameter int ID_W           = 8
) (
  input logic clk,
  input logic rst,
  sha3_scan_job_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(QUEUE_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  typedef struct packed {
    logic [63:0]                     thr;
    logic [INPUT_ELEMENTS-1:0][31:0] blob;
    logic [31:0]                     budget;
    logic [ID_W-1:0]                 id;
  } job_t;

  job_t             r_queue [QUEUE_DEPTH];
  job_t             r_run;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_job_ready;
  logic [ID_W-1:0]  r_next_id;
  logic [1:0]       r_state;
  logic [31:0]      r_base;
  logic             r_res_valid;
  logic [ID_W-1:0]  r_res_id;
  logic             r_res_found;
  logic [31:0]      r_res_nonce;
  logic [31:0]      r_res_scanned;
  logic [15:0]      r_stale;

  logic             w_push;
  logic             w_queued;
  logic             w_pop;
  logic [PTR_W:0]   w_count_next;
  logic [31:0]      w_delta;
  logic             w_exhausted;
  job_t             w_job_in;

  assign w_push       = bus.job_valid && r_job_ready;
  assign w_queued     = (r_count != '0);
  assign w_pop        = w_queued &&
                        ((r_state == ST_IDLE) || (r_state == ST_REPORT && bus.res_ready));
  assign w_count_next = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  assign w_delta      = bus.scan_count - r_base;
  assign w_exhausted  = (r_run.budget != 32'd0) && (w_delta >= r_run.budget);

  assign w_job_in.thr    = bus.job_threshold;
  assign w_job_in.blob   = bus.job_blobby;
  assign w_job_in.budget = bus.job_budget;
  assign w_job_in.id     = r_next_id;

  // Queue storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_queue[r_wr_ptr] <= w_job_in;
  end

  // Ready is a registered view of occupancy, so a full queue stays not-ready
  // even in a cycle where the head is being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_job_ready <= 1'b1;
      r_next_id   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_next_id <= r_next_id + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_job_ready <= (w_count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_run         <= '0;
      r_base        <= '0;
      r_res_valid   <= 1'b0;
      r_res_id      <= '0;
      r_res_found   <= 1'b0;
      r_res_nonce   <= '0;
      r_res_scanned <= '0;
    end else begin
      if (w_pop) r_run <= r_queue[r_rd_ptr];
      case (r_state)
        ST_IDLE: begin
          if (w_pop) r_state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          r_base  <= bus.scan_count;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Capture takes priority over exhaustion when both land together.
          if (bus.scan_capture || w_exhausted) begin
            r_res_found   <= bus.scan_capture;
            r_res_nonce   <= bus.scan_capture ? bus.scan_nonce : 32'd0;
            r_res_scanned <= w_delta;
            r_res_id      <= r_run.id;
            r_res_valid   <= 1'b1;
            r_state       <= ST_REPORT;
          end
        end
        default: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_queued ? ST_LAUNCH : ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stale <= '0;
    end else if (bus.scan_capture && r_state != ST_RUN && r_stale != 16'hFFFF) begin
      r_stale <= r_stale + 16'd1;
    end
  end

  assign bus.job_ready      = r_job_ready;
  assign bus.scan_start     = (r_state == ST_LAUNCH);
  assign bus.scan_threshold = r_run.thr;
  assign bus.scan_blobby    = r_run.blob;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_id         = r_res_id;
  assign bus.res_found      = r_res_found;
  assign bus.res_nonce      = r_res_nonce;
  assign bus.res_scanned    = r_res_scanned;
  assign bus.stale_drops    = r_stale;
  assign bus.seq_state      = r_state;
endmodule

// File: tb/tb_sha3_scan_job_sequencer.sv
// Directed bench for sha3_scan_job_sequencer: scoreboard of expected result
// records, immediate-assertion checks, bench-driven scanner counter.
module tb_sha3_scan_job_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_starts = 0;
  logic scan_auto = 1'b0;
  logic [7:0] tb_res_id = 8'd0;

  typedef struct {
    logic [7:0]  id;
    logic        found;
    logic [31:0] nonce;
    logic [31:0] scanned;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  sha3_scan_job_sequencer_if #(.INPUT_ELEMENTS(20), .ID_W(8)) bus ();

  sha3_scan_job_sequencer #(.INPUT_ELEMENTS(20), .QUEUE_DEPTH(2), .ID_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.scan_start === 1'b1) n_starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (scan_auto) bus.scan_count = bus.scan_count + 32'd1;
  endtask

  task automatic expect_res(input logic found, input logic [31:0] nonce, input logic [31:0] scanned);
    res_t e;
    e.id = tb_res_id; e.found = found; e.nonce = nonce; e.scanned = scanned;
    exp_q.push_back(e);
    tb_res_id = tb_res_id + 8'd1;
  endtask

  task automatic push_job(input logic [63:0] thr, input logic [31:0] budget, input logic [31:0] seed);
    chk("job_ready_pre_push", bus.job_ready, 1);
    bus.job_valid     = 1'b1;
    bus.job_threshold = thr;
    bus.job_budget    = budget;
    for (int i = 0; i < 20; i++) bus.job_blobby[i] = seed ^ 32'(i);
    step();
    bus.job_valid = 1'b0;
  endtask

  task automatic capture(input logic [31:0] delta, input logic [31:0] nonce);
    expect_res(1'b1, nonce, delta);
    bus.scan_count   = bus.scan_count + delta;
    bus.scan_capture = 1'b1;
    bus.scan_nonce   = nonce;
    step();
    bus.scan_capture = 1'b0;
    bus.scan_nonce   = 32'd0;
    chk("capture_to_res_valid", bus.res_valid, 1);
  endtask

  task automatic take_result();
    res_t e;
    int   waited = 0;
    while (bus.res_valid !== 1'b1 && waited < 400) begin
      step();
      waited++;
    end
    chk("res_valid_seen", bus.res_valid, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("res_id", bus.res_id, e.id);
      chk("res_found", bus.res_found, e.found);
      chk("res_nonce", bus.res_nonce, e.nonce);
      chk("res_scanned", bus.res_scanned, e.scanned);
      $display("[TB] result id=%0d found=%0d nonce=%08h scanned=%0d", bus.res_id, bus.res_found,
               bus.res_nonce, bus.res_scanned);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_valid_cleared", bus.res_valid, 0);
  endtask

  initial begin
    int starts0;
    rst               = 1'b1;
    bus.job_valid     = 1'b0;
    bus.job_threshold = '0;
    bus.job_blobby    = '0;
    bus.job_budget    = '0;
    bus.scan_busy     = 1'b0;
    bus.scan_capture  = 1'b0;
    bus.scan_nonce    = '0;
    bus.scan_count    = 32'd1000;
    bus.res_ready     = 1'b0;
    step();
    step();
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_scan_start", bus.scan_start, 0);
    chk("rst_seq_state", bus.seq_state, 0);
    chk("rst_stale", bus.stale_drops, 0);
    chk("rst_threshold", bus.scan_threshold, 0);
    rst = 1'b0;
    step();

    // Single job, unlimited budget, capture 37 counts after launch.
    push_job(64'hA5A5_0000_1111_2222, 32'd0, 32'h1000_0000);
    chk("t1_idle_after_push", bus.seq_state, 0);
    step();
    chk("t1_scan_start", bus.scan_start, 1);
    chk("t1_launch_state", bus.seq_state, 1);
    chk("t1_threshold", bus.scan_threshold, 64'hA5A5_0000_1111_2222);
    chk("t1_blob3", bus.scan_blobby[3], 32'h1000_0003);
    step();
    chk("t1_start_one_cycle", bus.scan_start, 0);
    chk("t1_run_state", bus.seq_state, 2);
    capture(32'd37, 32'h1234_5678);
    take_result();
    chk("t1_back_idle", bus.seq_state, 0);

    // Budget 100 with a free-running counter and no capture.
    scan_auto = 1'b1;
    expect_res(1'b0, 32'd0, 32'd100);
    push_job(64'h1, 32'd100, 32'h2000_0000);
    take_result();
    scan_auto = 1'b0;

    // Capture on the same cycle the budget is reached.
    push_job(64'h2, 32'd50, 32'h3000_0000);
    step();
    step();
    capture(32'd50, 32'h0000_CAFE);
    take_result();

    // Three jobs back to back into a 2-deep queue.
    starts0 = n_starts;
    push_job(64'h10, 32'd0, 32'h4000_0000);
    push_job(64'h11, 32'd0, 32'h5000_0000);
    chk("t4_first_launch", bus.scan_start, 1);
    push_job(64'h12, 32'd0, 32'h6000_0000);
    chk("t4_ready_full", bus.job_ready, 0);
    chk("t4_running", bus.seq_state, 2);
    capture(32'd10, 32'hAAAA_0000);
    take_result();
    chk("t4_report_to_launch_a", bus.seq_state, 1);
    chk("t4_threshold_b", bus.scan_threshold, 64'h11);
    step();
    capture(32'd11, 32'hAAAA_0001);
    take_result();
    chk("t4_report_to_launch_b", bus.seq_state, 1);
    step();
    capture(32'd12, 32'hAAAA_0002);
    take_result();
    chk("t4_back_idle", bus.seq_state, 0);
    step();
    chk("t4_start_count", 64'(n_starts - starts0), 3);

    // Wrapped counter base, result held under back-pressure while stale captures arrive.
    bus.scan_count = 32'hFFFF_FFF0;
    push_job(64'h20, 32'd0, 32'h7000_0000);
    step();
    step();
    capture(32'd21, 32'hBEEF_0001);
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 1) begin
        bus.scan_capture = 1'b1;
        bus.scan_nonce   = 32'(k);
        bus.scan_count   = bus.scan_count + 32'd7;
      end
      step();
      bus.scan_capture = 1'b0;
      chk("t5_hold_valid", bus.res_valid, 1);
      chk("t5_hold_nonce", bus.res_nonce, 32'hBEEF_0001);
      chk("t5_hold_scanned", bus.res_scanned, 32'd21);
    end
    chk("t5_stale_drops", bus.stale_drops, 3);
    take_result();

    // Reset while a job is running: no result, ids restart.
    push_job(64'h30, 32'd0, 32'h8000_0000);
    step();
    step();
    chk("t6_running", bus.seq_state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_state", bus.seq_state, 0);
    chk("t6_res_valid", bus.res_valid, 0);
    chk("t6_job_ready", bus.job_ready, 1);
    chk("t6_stale", bus.stale_drops, 0);
    chk("t6_threshold", bus.scan_threshold, 0);
    chk("t6_res_nonce", bus.res_nonce, 0);
    chk("t6_res_scanned", bus.res_scanned, 0);
    chk("t6_res_id", bus.res_id, 0);
    step();
    chk("t6_no_late_result", bus.res_valid, 0);
    tb_res_id = 8'd0;
    push_job(64'h31, 32'd0, 32'h9000_0000);
    step();
    step();
    capture(32'd5, 32'h0000_0077);
    take_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
